regbank_write_arbiter: RTL and testbench

Write-port arbiter for the 16x16 register bank. It shares the bank's single write port (data bus plus 4-bit destination index) between NREQ requesters, such as the ALU result, memory load and link/immediate writes. It uses round-robin arbitration with an optional per-requester lock for back-to-back bursts. Its registered write stage drives the bank's data and destination inputs directly.

---
 rtl/regbank_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regbank_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter for the 16x16 register bank, with per-requester
// lock bursts and a registered write stage. Optional build macro: REGBANK_R0_ZERO_EN.
module regbank_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [4*NREQ-1:0]    dest,
  input  logic [DW*NREQ-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_en,
  output logic [3:0]           wr_dest,
  output logic [DW-1:0]        wr_data,
  output logic                 locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   off;
  logic [PW-1:0]   pick_idx;
  logic [PW:0]     pick_sum;
  logic            found;
  logic [2*NREQ-1:0] req_rot;
  logic            xfer;
  logic            wr_ok;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] i);
    if (i == PW'(NREQ - 1)) return '0;
    return i + PW'(1);
  endfunction

  // Rotate req so bit 0 is the requester at ptr; the first set bit is the winner.
  always_comb begin
    req_rot  = {req, req} >> ptr;
    found    = 1'b0;
    off      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
    pick_sum = {1'b0, ptr} + {1'b0, off};
    if (pick_sum >= (PW+1)'(NREQ)) pick_sum = pick_sum - (PW+1)'(NREQ);
    pick_idx = pick_sum[PW-1:0];
  end

  always_comb begin
    gnt       = '0;
    sel       = '0;
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    if (reset) begin
      if (state == ARB) begin
        if (found) begin
          gnt[pick_idx] = 1'b1;
          sel           = pick_idx;
        end
      end else begin
        gnt[owner] = req[owner];
        sel        = owner;
      end
    end
    xfer = |gnt;
    if (xfer) begin
      case (state)
        ARB: begin
          ptr_nxt = inc_mod(sel);
          if (lock[sel]) begin
            state_nxt = LOCK;
            owner_nxt = sel;
          end
        end
        LOCK: begin
          if (!lock[owner]) begin
            state_nxt = ARB;
            ptr_nxt   = inc_mod(owner);
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // With r0 protection the transfer still completes, but no bank write is issued.
`ifdef REGBANK_R0_ZERO_EN
  assign wr_ok = xfer && (dest[4*sel +: 4] != 4'd0);
`else
  assign wr_ok = xfer;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ARB;
      ptr     <= '0;
      owner   <= '0;
      wr_en   <= 1'b0;
      wr_dest <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      wr_en   <= wr_ok;
      if (wr_ok) begin
        wr_dest <= dest[4*sel +: 4];
        wr_data <= data[DW*sel +: DW];
      end
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter (NREQ=3, DW=16).
module tb_regbank_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     lock;
  logic [4*NREQ-1:0]   dest;
  logic [DW*NREQ-1:0]  data;
  logic [NREQ-1:0]     gnt;
  logic                wr_en;
  logic [3:0]          wr_dest;
  logic [DW-1:0]       wr_data;
  logic                locked;

  int checks = 0;
  int errors = 0;

  regbank_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .dest    (dest),
    .data    (data),
    .gnt     (gnt),
    .wr_en   (wr_en),
    .wr_dest (wr_dest),
    .wr_data (wr_data),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Short reset pulse starting at a falling edge; returns 2ns later with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b111;
    lock  = '0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_dest !== 4'd0) begin errors++; $display("[TB] FAIL reset_wr_dest got %h want 0", wr_dest); end
    checks++; if (wr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wr_data got %h want 0000", wr_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL reset_first_gnt got %b want 001", gnt); end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    req  = 3'b111;
    lock = 3'b000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
      end
      #1;
      exp_g = 3'b001 << (k % 3);
      checks++; if (gnt !== exp_g) begin errors++; $display("[TB] FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g); end
      if (k > 0) begin
        checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL rr_wr_en[%0d] got %b want 1", k, wr_en); end
        checks++; if (wr_data !== 16'hA000 + 16'((k-1) % 3)) begin errors++; $display("[TB] FAIL rr_wr_data[%0d] got %h want %h", k, wr_data, 16'hA000 + 16'((k-1) % 3)); end
        checks++; if (wr_dest !== 4'((k-1) % 3 + 1)) begin errors++; $display("[TB] FAIL rr_wr_dest[%0d] got %h want %h", k, wr_dest, 4'((k-1) % 3 + 1)); end
      end
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_data !== 16'hA002) begin errors++; $display("[TB] FAIL rr_last_write got en=%b data=%h want en=1 data=a002", wr_en, wr_data); end
    @(negedge clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_wr_en got %b want 0", wr_en); end
    checks++; if (wr_data !== 16'hA002) begin errors++; $display("[TB] FAIL rr_hold_wr_data got %h want a002", wr_data); end
  endtask

  task automatic test_lock();
    do_reset();
    req  = 3'b111;
    lock = 3'b010;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL lock_pre_gnt got %b want 001", gnt); end
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010 || locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_take got gnt=%b locked=%b want 010/0", gnt, locked); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) lock = 3'b000;
      #1;
      checks++; if (gnt !== 3'b010 || locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_hold[%0d] got gnt=%b locked=%b want 010/1", k, gnt, locked); end
      checks++; if (wr_en !== 1'b1 || wr_data !== 16'hA001) begin errors++; $display("[TB] FAIL lock_write[%0d] got en=%b data=%h want 1/a001", k, wr_en, wr_data); end
    end
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b100 || locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_release got gnt=%b locked=%b want 100/0", gnt, locked); end
    req = '0;
  endtask

  task automatic test_lock_idle();
    do_reset();
    req  = 3'b001;
    lock = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL idle_take got %b want 001", gnt); end
    @(negedge clk);
    req  = 3'b100;
    lock = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL idle_gnt[%0d] got %b want 000", k, gnt); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL idle_locked[%0d] got %b want 1", k, locked); end
      checks++; if (wr_en !== (k == 0)) begin errors++; $display("[TB] FAIL idle_wr_en[%0d] got %b want %b", k, wr_en, (k == 0)); end
    end
    @(negedge clk);
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL idle_release_gnt got %b want 001", gnt); end
    @(negedge clk);
    req = 3'b101;
    #1;
    checks++; if (gnt !== 3'b100 || locked !== 1'b0) begin errors++; $display("[TB] FAIL idle_after got gnt=%b locked=%b want 100/0", gnt, locked); end
    req = '0;
  endtask

  task automatic test_reset_burst();
    do_reset();
    req  = 3'b001;
    lock = 3'b001;
    @(negedge clk);
    req = 3'b000;
    #1;
    checks++; if (locked !== 1'b1 || wr_en !== 1'b1) begin errors++; $display("[TB] FAIL burst_pre got locked=%b en=%b want 1/1", locked, wr_en); end
    reset = 1'b0;
    #1;
    checks++; if (locked !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("[TB] FAIL burst_async_clear got locked=%b en=%b want 0/0", locked, wr_en); end
    #2;
    reset = 1'b1;
    req   = 3'b101;
    lock  = 3'b000;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL burst_ptr_zero got %b want 001", gnt); end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 3'b010;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL wrap_first got %b want 010", gnt); end
    @(negedge clk);
    req = 3'b011;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL wrap_pick got %b want 001", gnt); end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_r0();
    do_reset();
    dest[3:0]  = 4'd0;
    data[15:0] = 16'hBEEF;
    req        = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL r0_gnt got %b want 001", gnt); end
    @(negedge clk);
    req = '0;
    #1;
`ifdef REGBANK_R0_ZERO_EN
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL r0_suppress got en=%b want 0", wr_en); end
`else
    checks++; if (wr_en !== 1'b1 || wr_dest !== 4'd0 || wr_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL r0_write got en=%b dest=%h data=%h want 1/0/beef", wr_en, wr_dest, wr_data); end
`endif
    dest[3:0]  = 4'd1;
    data[15:0] = 16'hA000;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    dest  = {4'd3, 4'd2, 4'd1};
    data  = {16'hA002, 16'hA001, 16'hA000};
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_idle();
    test_reset_burst();
    test_wrap();
    test_r0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
